// File: rtl/alu_exec_if.sv
// alu_exec_if: instruction handshake, ALU operand/result and writeback signals of alu_exec_ctrl.
interface alu_exec_if #(
    parameter int DATA_W = 16,
    parameter int RA_W = 3
) ();
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [RA_W-1:0]   instr_rd;
    logic [RA_W-1:0]   instr_ra;
    logic [RA_W-1:0]   instr_rb;
    logic [DATA_W-1:0] instr_imm;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_select;
    logic              alu_enable;
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry;
    logic              wb_valid;
    logic [RA_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              flag_carry;
    logic              flag_zero;
    logic              illegal_op;
    modport master (
        output instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm, alu_out, alu_carry,
        input  instr_ready, alu_a, alu_b, alu_select, alu_enable, wb_valid, wb_rd, wb_data,
               flag_carry, flag_zero, illegal_op
    );
    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm, alu_out, alu_carry,
        output instr_ready, alu_a, alu_b, alu_select, alu_enable, wb_valid, wb_rd, wb_data,
               flag_carry, flag_zero, illegal_op
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: one-instruction-in-flight controller with a register file driving an external ALU.
module alu_exec_ctrl #(
    parameter int DATA_W = 16,
    parameter int RA_W = 3
) (
    input logic clk,
    input logic rst_n,
    alu_exec_if.slave bus
);
    localparam int NREG = 1 << RA_W;
    localparam logic [2:0] OP_LDI = 3'b100;
    typedef enum logic [1:0] {IDLE, OPER, EXEC, WB} state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [2:0]        op_q, op_d;
    logic [RA_W-1:0]   rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]        alu_sel_q, alu_sel_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              flag_carry_q, flag_carry_d, flag_zero_q, flag_zero_d;
    logic              illegal_q, illegal_d;
    logic              accept;
    logic [DATA_W-1:0] rf_a, rf_b;

    always_comb begin
        accept       = state_q == IDLE && bus.instr_valid;
        rf_a         = rf_q[ra_q];
        rf_b         = rf_q[rb_q];
        state_d      = state_q;
        rf_d         = rf_q;
        op_d         = op_q;
        rd_d         = rd_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        flag_carry_d = flag_carry_q;
        flag_zero_d  = flag_zero_q;
        illegal_d    = 1'b0;
        if (accept) begin
            op_d      = bus.instr_op;
            rd_d      = bus.instr_rd;
            ra_d      = bus.instr_ra;
            rb_d      = bus.instr_rb;
            illegal_d = bus.instr_op > OP_LDI;
            state_d   = bus.instr_op > OP_LDI ? IDLE : bus.instr_op == OP_LDI ? WB : OPER;
            // LDI skips the ALU entirely: its writeback is staged straight from the immediate
            if (bus.instr_op == OP_LDI) begin
                wb_valid_d  = 1'b1;
                wb_rd_d     = bus.instr_rd;
                wb_data_d   = bus.instr_imm;
                flag_zero_d = bus.instr_imm == '0;
            end
        end
        if (state_q == OPER) begin
            alu_a_d   = rf_a;
            alu_b_d   = rf_b;
            alu_sel_d = op_q;
            state_d   = EXEC;
        end
        if (state_q == EXEC) begin
            state_d      = WB;
            wb_valid_d   = 1'b1;
            wb_rd_d      = rd_q;
            wb_data_d    = bus.alu_out;
            flag_zero_d  = bus.alu_out == '0;
            flag_carry_d = op_q[2:1] == 2'b00 ? bus.alu_carry : flag_carry_q;
        end
        if (state_q == WB) begin
            state_d = IDLE;
            if (wb_rd_q != '0) rf_d[wb_rd_q] = wb_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            ra_q         <= '0;
            rb_q         <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            flag_carry_q <= 1'b0;
            flag_zero_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_q         <= rf_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            ra_q         <= ra_d;
            rb_q         <= rb_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            flag_carry_q <= flag_carry_d;
            flag_zero_q  <= flag_zero_d;
            illegal_q    <= illegal_d;
        end
    end

    // Operands come straight from the register file in OPER so the prior writeback is visible
    assign bus.instr_ready = state_q == IDLE;
    assign bus.alu_enable  = state_q == OPER || state_q == EXEC;
    assign bus.alu_a       = state_q == OPER ? rf_a : alu_a_q;
    assign bus.alu_b       = state_q == OPER ? rf_b : alu_b_q;
    assign bus.alu_select  = state_q == OPER ? op_q : alu_sel_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.flag_carry  = flag_carry_q;
    assign bus.flag_zero   = flag_zero_q;
    assign bus.illegal_op  = illegal_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: random and directed instruction streams checked against a behavioural model
// with a one-cycle-latency ALU that returns garbage whenever it is not enabled.
module tb_alu_exec_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    alu_exec_if #(.DATA_W(16), .RA_W(3)) bus ();
    alu_exec_ctrl #(.DATA_W(16), .RA_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
        return s == 3'd0 ? {1'b0, a} + {1'b0, b} :
               s == 3'd1 ? {1'b0, a} - {1'b0, b} :
               s == 3'd2 ? {1'($urandom), a ^ b} :
               s == 3'd3 ? {1'($urandom), a & b} : 17'($urandom);
    endfunction

    always @(posedge clk)
        if (bus.alu_enable) {bus.alu_carry, bus.alu_out} <= alu_f(bus.alu_a, bus.alu_b, bus.alu_select);
        else {bus.alu_carry, bus.alu_out} <= 17'($urandom);

    // Behavioural model: each accepted instruction's result is computed at acceptance and
    // expected on the bus a fixed number of cycles later.
    logic [15:0] m_reg [8];
    logic [15:0] m_alu_a = '0, m_alu_b = '0, m_wb_data = '0, p_res = '0, p_a = '0, p_b = '0;
    logic [2:0]  m_sel = '0, m_wb_rd = '0, p_op = '0, p_rd = '0;
    logic        m_fc = 1'b0, m_fz = 1'b0, p_carry = 1'b0;
    bit          busy = 1'b0, done = 1'b0;
    int          cyc = 0, wb_at = 0, ill_at = -1;

    initial begin
        bit en, wb;
        int sum;
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (done) begin
                busy = 1'b0;
                done = 1'b0;
            end else if (rst_n && !busy && bus.instr_valid) begin
                if (bus.instr_op > 3'd4) ill_at = cyc;
                else begin
                    busy  = 1'b1;
                    p_op  = bus.instr_op;
                    p_rd  = bus.instr_rd;
                    p_a   = m_reg[bus.instr_ra];
                    p_b   = m_reg[bus.instr_rb];
                    wb_at = p_op == 3'd4 ? cyc : cyc + 2;
                    p_carry = 1'b0;
                    if (p_op == 3'd0) begin
                        sum = int'(p_a) + int'(p_b);
                        p_res = 16'(sum);
                        p_carry = sum > 65535;
                    end else if (p_op == 3'd1) begin
                        p_res = 16'(int'(p_a) - int'(p_b));
                        p_carry = p_a < p_b;
                    end else if (p_op == 3'd2) p_res = p_a ^ p_b;
                    else if (p_op == 3'd3) p_res = p_a & p_b;
                    else p_res = bus.instr_imm;
                end
            end
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0; done = 1'b0; ill_at = -1;
                for (int i = 0; i < 8; i++) m_reg[i] = '0;
                m_alu_a = '0; m_alu_b = '0; m_sel = '0;
                m_wb_rd = '0; m_wb_data = '0; m_fc = 1'b0; m_fz = 1'b0;
            end
            en = busy && p_op != 3'd4 && (cyc == wb_at - 2 || cyc == wb_at - 1);
            wb = busy && cyc == wb_at;
            if (en) begin
                m_alu_a = p_a; m_alu_b = p_b; m_sel = p_op;
            end
            if (wb) begin
                m_wb_rd = p_rd; m_wb_data = p_res; m_fz = p_res == '0;
                if (p_op < 3'd2) m_fc = p_carry;
                if (p_rd != '0) m_reg[p_rd] = p_res;
                done = 1'b1;
            end
            chk("instr_ready", 32'(bus.instr_ready), 32'(!busy));
            chk("illegal_op", 32'(bus.illegal_op), 32'(rst_n && cyc == ill_at));
            chk("alu_enable", 32'(bus.alu_enable), 32'(en));
            chk("alu_a", 32'(bus.alu_a), 32'(m_alu_a));
            chk("alu_b", 32'(bus.alu_b), 32'(m_alu_b));
            chk("alu_select", 32'(bus.alu_select), 32'(m_sel));
            chk("wb_valid", 32'(bus.wb_valid), 32'(wb));
            chk("wb_rd", 32'(bus.wb_rd), 32'(m_wb_rd));
            chk("wb_data", 32'(bus.wb_data), 32'(m_wb_data));
            chk("flag_carry", 32'(bus.flag_carry), 32'(m_fc));
            chk("flag_zero", 32'(bus.flag_zero), 32'(m_fz));
        end
    end

    // Offers an instruction until accepted; while busy the fields are scrambled to prove they are ignored.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [15:0] imm);
        int t = 0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.instr_ready) begin
                bus.instr_op = op; bus.instr_rd = rd; bus.instr_ra = ra;
                bus.instr_rb = rb; bus.instr_imm = imm; bus.instr_valid = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            bus.instr_op = 3'($urandom); bus.instr_rd = 3'($urandom); bus.instr_ra = 3'($urandom);
            bus.instr_rb = 3'($urandom); bus.instr_imm = 16'($urandom); bus.instr_valid = 1'b1;
            if (++t > 20) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: instr_ready stayed 0 for %0d cycles", t);
                break;
            end
        end
    endtask

    task automatic expect_wb(input logic [2:0] rd, input logic [15:0] data, input logic fz,
                             input logic fc, input int lat);
        int t = 0;
        while (t < 8) begin
            @(negedge clk);
            if (bus.wb_valid) break;
            t++;
        end
        chk("lit_latency", 32'(t), 32'(lat));
        chk("lit_wb_rd", 32'(bus.wb_rd), 32'(rd));
        chk("lit_wb_data", 32'(bus.wb_data), 32'(data));
        chk("lit_flag_zero", 32'(bus.flag_zero), 32'(fz));
        chk("lit_flag_carry", 32'(bus.flag_carry), 32'(fc));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            bus.instr_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] op;
        logic [15:0] imm;
        bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rd = '0;
        bus.instr_ra = '0; bus.instr_rb = '0; bus.instr_imm = '0;
        #1;
        chk("lit_rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("lit_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(3'd4, 3'd1, 3'd0, 3'd0, 16'h0002); expect_wb(3'd1, 16'h0002, 1'b0, 1'b0, 0);
        issue(3'd4, 3'd2, 3'd0, 3'd0, 16'h0002); expect_wb(3'd2, 16'h0002, 1'b0, 1'b0, 0);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000); expect_wb(3'd3, 16'h0004, 1'b0, 1'b0, 2);
        issue(3'd4, 3'd1, 3'd0, 3'd0, 16'hFFFF); expect_wb(3'd1, 16'hFFFF, 1'b0, 1'b0, 0);
        issue(3'd4, 3'd2, 3'd0, 3'd0, 16'h0001); expect_wb(3'd2, 16'h0001, 1'b0, 1'b0, 0);
        issue(3'd0, 3'd4, 3'd1, 3'd2, 16'h0000); expect_wb(3'd4, 16'h0000, 1'b1, 1'b1, 2);
        issue(3'd2, 3'd5, 3'd1, 3'd2, 16'h0000); expect_wb(3'd5, 16'hFFFE, 1'b0, 1'b1, 2);
        issue(3'd6, 3'd3, 3'd1, 3'd2, 16'h0000);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("lit_illegal_pulse", 32'(bus.illegal_op), 32'd1);
        chk("lit_illegal_no_wb", 32'(bus.wb_valid), 32'd0);
        chk("lit_illegal_ready", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        chk("lit_illegal_end", 32'(bus.illegal_op), 32'd0);
        issue(3'd2, 3'd6, 3'd3, 3'd0, 16'h0000); expect_wb(3'd6, 16'h0004, 1'b0, 1'b1, 2);
        issue(3'd4, 3'd0, 3'd0, 3'd0, 16'h1234); expect_wb(3'd0, 16'h1234, 1'b0, 1'b1, 0);
        issue(3'd3, 3'd6, 3'd0, 3'd1, 16'h0000); expect_wb(3'd6, 16'h0000, 1'b1, 1'b1, 2);
        issue(3'd4, 3'd1, 3'd0, 3'd0, 16'h0003); expect_wb(3'd1, 16'h0003, 1'b0, 1'b1, 0);
        issue(3'd0, 3'd7, 3'd1, 3'd1, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        #1;
        chk("lit_abort_ready", 32'(bus.instr_ready), 32'd1);
        chk("lit_abort_enable", 32'(bus.alu_enable), 32'd0);
        chk("lit_abort_alu_a", 32'(bus.alu_a), 32'd0);
        chk("lit_abort_flag_carry", 32'(bus.flag_carry), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(3'd4, 3'd5, 3'd0, 3'd0, 16'h00AB); expect_wb(3'd5, 16'h00AB, 1'b0, 1'b0, 0);
        issue(3'd0, 3'd6, 3'd7, 3'd5, 16'h0000); expect_wb(3'd6, 16'h00AB, 1'b0, 1'b0, 2);
        repeat (250) begin
            op = $urandom_range(0, 9) < 8 ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            imm = $urandom_range(0, 5) == 0 ? 16'hFFFF : $urandom_range(0, 5) == 0 ? 16'h0000 : 16'($urandom);
            issue(op, 3'($urandom), 3'($urandom), 3'($urandom), imm);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        idle(6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 The block SHALL take parameter DATA_W, default 16, data path width.
REQ-003 The block SHALL take parameter RA_W, default 3, register address width (2**RA_W registers).
REQ-004 Ports SHALL be exactly:
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept instruction
- instr_op  in  3  000 ADD, 001 SUB, 010 XOR, 011 AND, 100 LDI, 101-111 illegal
- instr_rd  in  RA_W  destination register
- instr_ra  in  RA_W  source A register
- instr_rb  in  RA_W  source B register
- instr_imm  in  DATA_W  immediate (LDI only)
- alu_a  out  DATA_W  ALU operand A
- alu_b  out  DATA_W  ALU operand B
- alu_select  out  3  ALU operation code
- alu_enable  out  1  ALU evaluate strobe
- alu_out  in  DATA_W  ALU result
- alu_carry  in  1  ALU carry
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  RA_W  writeback register
- wb_data  out  DATA_W  writeback value
- flag_carry  out  1  carry flag
- flag_zero  out  1  zero flag
- illegal_op  out  1  one-cycle illegal-opcode pulse

Function
REQ-005 The block SHALL contain 2**RA_W registers of DATA_W bits; register 0 SHALL always read 0, writes to it discarded.
REQ-006 FSM states SHALL be IDLE, OPER, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-007 Handshake: instruction accepted on a rising edge with instr_valid=1 and instr_ready=1; all instr_* fields latched at that edge; fields ignored otherwise.
REQ-008 IDLE -> OPER on accepting ops 000-011; IDLE -> WB on accepting LDI; illegal op: stay IDLE, illegal_op=1 for the next cycle only, no register or flag change.
REQ-009 OPER (1 cycle): alu_a=reg[ra], alu_b=reg[rb], alu_select=op, alu_enable=1; -> EXEC.
REQ-010 EXEC (1 cycle): operands, select, alu_enable=1 held; alu_out and alu_carry captured at end of EXEC; -> WB.
REQ-011 Outside OPER/EXEC, alu_enable SHALL be 0; alu_a, alu_b, alu_select SHALL hold last driven values.
REQ-012 WB (1 cycle): wb_valid=1, wb_rd=latched rd, wb_data=captured result (LDI: latched imm); register written at end of WB; -> IDLE.
REQ-013 wb_rd and wb_data SHALL hold their values when wb_valid=0.
REQ-014 Latency: ALU op accepted at edge N -> wb_valid high in cycle after edge N+2; LDI -> cycle after edge N; one instruction in flight, next acceptance no earlier than the edge ending WB.
REQ-015 Operands SHALL be read in OPER, so a register written by the previous instruction's WB is seen (no hazard).
REQ-016 flag_zero SHALL update in WB for ops 000-011 and LDI: 1 iff wb_data==0.
REQ-017 flag_carry SHALL update in WB from captured alu_carry for ADD and SUB only; XOR, AND, LDI hold it.
REQ-018 Destination 0: wb_valid still pulses and flags still update; register 0 stays 0.
REQ-019 All state SHALL be registered; no combinational path from instr_* to any output except none (instr_ready depends on state only).

Reset
REQ-020 While rst_n=0, asynchronously: state=IDLE, all registers 0, alu_a=alu_b=0, alu_select=000, alu_enable=0, wb_valid=0, wb_rd=0, wb_data=0, flag_carry=0, flag_zero=0, illegal_op=0; instr_ready=1.
REQ-021 Reset mid-instruction SHALL abort it with no register write; the first edge after rst_n rises may accept a new instruction.

Verification
REQ-022 LDI r1,0x0002; LDI r2,0x0002; ADD r3,r1,r2 -> wb_data=0x0004 rd=3 three cycles after acceptance, flag_zero=0.
REQ-023 LDI r1,0xFFFF; LDI r2,0x0001; ADD r4,r1,r2 -> wb_data=0x0000, flag_zero=1, flag_carry=alu_carry sampled in EXEC; then XOR r5,r1,r2 -> wb_data=0xFFFE, flag_carry unchanged.
REQ-024 instr_valid held high across back-to-back instructions -> instr_ready low in OPER/EXEC/WB, each instruction accepted once, no field change mid-flight affects result.
REQ-025 op=110 offered -> illegal_op one-cycle pulse, wb_valid stays 0, registers and flags unchanged, instr_ready stays 1.
REQ-026 LDI r0,0x1234 then AND r6,r0,r1 -> first wb_data=0x1234 with r0 unchanged, second wb_data=0x0000.
REQ-027 rst_n pulsed low during EXEC of ADD r7 -> all outputs at reset values immediately, r7 remains 0, next LDI completes normally.
